cnl_result_checker: RTL

Synthesizable, parametrised result checker for the CNN layer accelerator quad, clocked on the interface clock. Joins the quad's result stream with an expected-result stream, one beat at a time. Tracks output row, column and depth position, and counts and captures mismatches. Generalises the single-lane, single-job checking done in scenario benches to multi-lane results and back-to-back jobs, so that convolution output can be checked in hardware (emulation/FPGA) as well as in simulation.

---
 rtl/cnl_verif_pkg.sv | 18 +
 rtl/cnl_result_checker_if.sv | 24 ++
 rtl/cnl_result_lane_cmp.sv | 29 ++
 rtl/cnl_result_checker.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cnl_verif_pkg.sv
// Shared types and helpers for the CNN-accelerator result checker.
package cnl_verif_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_e;

  localparam int unsigned CNL_MISMATCH_CNT_W = 32;

  // Bit offset of lane `lane_idx` inside a packed multi-lane bus.
  function automatic int unsigned cnl_lane_lsb(input int unsigned lane_w,
                                               input int unsigned lane_idx);
    return lane_w * lane_idx;
  endfunction

endpackage

// File: rtl/cnl_result_checker_if.sv
// Result and expected-result streams joined by the checker.
interface cnl_result_checker_if #(
  parameter int unsigned C_RESULT_WIDTH = 16,
  parameter int unsigned C_NUM_CH       = 1
);

  logic                               result_valid;
  logic                               result_accept;
  logic [C_NUM_CH*C_RESULT_WIDTH-1:0] result_data;
  logic                               exp_valid;
  logic                               exp_ready;
  logic [C_NUM_CH*C_RESULT_WIDTH-1:0] exp_data;

  modport master (
    output result_valid, result_data, exp_valid, exp_data,
    input  result_accept, exp_ready
  );

  modport slave (
    input  result_valid, result_data, exp_valid, exp_data,
    output result_accept, exp_ready
  );

endinterface

// File: rtl/cnl_result_lane_cmp.sv
// Single-lane compare: exact by default, absolute tolerance when CNL_RESULT_TOL_EN is defined.
module cnl_result_lane_cmp #(
  parameter int unsigned C_RESULT_WIDTH = 16,
  parameter int unsigned C_TOL          = 0
) (
  input  logic                      lane_active_i,
  input  logic [C_RESULT_WIDTH-1:0] result_lane_i,
  input  logic [C_RESULT_WIDTH-1:0] exp_lane_i,
  output logic                      mismatch_o
);

`ifdef CNL_RESULT_TOL_EN
  localparam int unsigned DW = C_RESULT_WIDTH + 1;

  logic [DW-1:0] diff;
  logic [DW-1:0] mag;

  // One extra bit holds any difference of two W-bit signed values without overflow.
  always_comb begin
    diff       = {result_lane_i[C_RESULT_WIDTH-1], result_lane_i}
               - {exp_lane_i[C_RESULT_WIDTH-1], exp_lane_i};
    mag        = diff[DW-1] ? (~diff + 1'b1) : diff;
    mismatch_o = lane_active_i && (mag > DW'(C_TOL));
  end
`else
  assign mismatch_o = lane_active_i && (result_lane_i != exp_lane_i);
`endif

endmodule

// File: rtl/cnl_result_checker.sv
// Joins result and expected streams beat by beat, tracks row/col/depth position and
// counts/captures lane mismatches. Optional macro: CNL_RESULT_TOL_EN (tolerant compare).
module cnl_result_checker
  import cnl_verif_pkg::*;
#(
  parameter int unsigned C_RESULT_WIDTH = 16,
  parameter int unsigned C_NUM_CH       = 1,
  parameter int unsigned C_DIM_WIDTH    = 10,
  parameter int unsigned C_TOL          = 0
) (
  input  logic                          clk_if,
  input  logic                          rst,
  input  logic                          start,
  input  logic [C_DIM_WIDTH-1:0]        num_output_rows_cfg,
  input  logic [C_DIM_WIDTH-1:0]        num_output_cols_cfg,
  input  logic [C_DIM_WIDTH-1:0]        num_kernel_cfg,
  cnl_result_checker_if.slave           bus,
  output logic [C_DIM_WIDTH-1:0]        output_row,
  output logic [C_DIM_WIDTH-1:0]        output_col,
  output logic [C_DIM_WIDTH-1:0]        output_depth,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [CNL_MISMATCH_CNT_W-1:0] mismatch_count,
  output logic [C_DIM_WIDTH-1:0]        first_err_row,
  output logic [C_DIM_WIDTH-1:0]        first_err_col,
  output logic [C_DIM_WIDTH-1:0]        first_err_depth
);

  localparam int unsigned PW = C_DIM_WIDTH + 1;  // depth compares need a carry bit

  chk_state_e                    state_q, state_d;
  logic [C_DIM_WIDTH-1:0]        rows_q, rows_d, cols_q, cols_d, kern_q, kern_d;
  logic [C_DIM_WIDTH-1:0]        row_q, row_d, col_q, col_d, depth_q, depth_d;
  logic [C_DIM_WIDTH-1:0]        fe_row_q, fe_row_d, fe_col_q, fe_col_d;
  logic [C_DIM_WIDTH-1:0]        fe_depth_q, fe_depth_d;
  logic                          error_q, error_d;
  logic [CNL_MISMATCH_CNT_W-1:0] cnt_q, cnt_d;

  logic                          running;
  logic                          fire;
  logic                          last_beat;
  logic                          any_mis;
  logic [C_NUM_CH-1:0]           lane_active;
  logic [C_NUM_CH-1:0]           lane_mis;
  logic [CNL_MISMATCH_CNT_W-1:0] mis_pop;
  logic [CNL_MISMATCH_CNT_W:0]   cnt_sum;
  logic [C_DIM_WIDTH-1:0]        low_lane;

  assign running           = (state_q == RUN);
  assign fire              = running && bus.result_valid && bus.exp_valid;
  assign bus.result_accept = running && bus.exp_valid;
  assign bus.exp_ready     = running && bus.result_valid;

  for (genvar k = 0; k < int'(C_NUM_CH); k++) begin : g_lane
    localparam int unsigned LSB = cnl_lane_lsb(C_RESULT_WIDTH, k);

    // Lanes past the last kernel of a partial depth group carry no real result.
    assign lane_active[k] = ({1'b0, depth_q} + PW'(k)) < {1'b0, kern_q};

    cnl_result_lane_cmp #(
      .C_RESULT_WIDTH (C_RESULT_WIDTH),
      .C_TOL          (C_TOL)
    ) u_cmp (
      .lane_active_i (lane_active[k]),
      .result_lane_i (bus.result_data[LSB +: C_RESULT_WIDTH]),
      .exp_lane_i    (bus.exp_data[LSB +: C_RESULT_WIDTH]),
      .mismatch_o    (lane_mis[k])
    );
  end

  always_comb begin
    mis_pop  = '0;
    low_lane = '0;
    for (int k = int'(C_NUM_CH) - 1; k >= 0; k--) begin
      mis_pop = mis_pop + CNL_MISMATCH_CNT_W'(lane_mis[k]);
      if (lane_mis[k]) low_lane = C_DIM_WIDTH'(k);
    end
  end

  assign any_mis   = |lane_mis;
  assign cnt_sum   = {1'b0, cnt_q} + {1'b0, mis_pop};
  assign last_beat = (col_q == cols_q - 1'b1) && (row_q == rows_q - 1'b1)
                  && (({1'b0, depth_q} + PW'(C_NUM_CH)) >= {1'b0, kern_q});

  always_comb begin
    // NOTE: every variable gets its default first; a path that skipped one would infer a latch.
    state_d    = state_q;
    rows_d     = rows_q;
    cols_d     = cols_q;
    kern_d     = kern_q;
    row_d      = row_q;
    col_d      = col_q;
    depth_d    = depth_q;
    fe_row_d   = fe_row_q;
    fe_col_d   = fe_col_q;
    fe_depth_d = fe_depth_q;
    error_d    = error_q;
    cnt_d      = cnt_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          rows_d     = num_output_rows_cfg;
          cols_d     = num_output_cols_cfg;
          kern_d     = num_kernel_cfg;
          row_d      = '0;
          col_d      = '0;
          depth_d    = '0;
          fe_row_d   = '0;
          fe_col_d   = '0;
          fe_depth_d = '0;
          error_d    = 1'b0;
          cnt_d      = '0;
          if ((num_output_rows_cfg == '0) || (num_output_cols_cfg == '0)
              || (num_kernel_cfg == '0)) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        if (fire) begin
          if (col_q == cols_q - 1'b1) begin
            col_d = '0;
            if (row_q == rows_q - 1'b1) begin
              row_d   = '0;
              depth_d = depth_q + C_DIM_WIDTH'(C_NUM_CH);
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end

          if (any_mis) begin
            cnt_d   = cnt_sum[CNL_MISMATCH_CNT_W] ? '1 : cnt_sum[CNL_MISMATCH_CNT_W-1:0];
            error_d = 1'b1;
            if (!error_q) begin
              fe_row_d   = row_q;
              fe_col_d   = col_q;
              fe_depth_d = depth_q + low_lane;
            end
          end

          if (last_beat) state_d = DONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_if or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rows_q     <= '0;
      cols_q     <= '0;
      kern_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      depth_q    <= '0;
      fe_row_q   <= '0;
      fe_col_q   <= '0;
      fe_depth_q <= '0;
      error_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples values from before this edge.
      state_q    <= state_d;
      rows_q     <= rows_d;
      cols_q     <= cols_d;
      kern_q     <= kern_d;
      row_q      <= row_d;
      col_q      <= col_d;
      depth_q    <= depth_d;
      fe_row_q   <= fe_row_d;
      fe_col_q   <= fe_col_d;
      fe_depth_q <= fe_depth_d;
      error_q    <= error_d;
      cnt_q      <= cnt_d;
    end
  end

  assign busy            = (state_q == RUN);
  assign done            = (state_q == DONE);
  assign error           = error_q;
  assign mismatch_count  = cnt_q;
  assign output_row      = row_q;
  assign output_col      = col_q;
  assign output_depth    = depth_q;
  assign first_err_row   = fe_row_q;
  assign first_err_col   = fe_col_q;
  assign first_err_depth = fe_depth_q;

endmodule
